// File: rtl/demux1x4_reg.sv
// One-to-four registered demultiplexer: routes each accepted word to the channel
// picked by {b1,b0}, where it waits in a one-entry buffer until that consumer takes it.
module demux1x4_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] e,
    input  logic         e_valid,
    output logic         e_ready,
    input  logic         b1,
    input  logic         b0,
    output logic [W-1:0] S0,
    output logic [W-1:0] S1,
    output logic [W-1:0] S2,
    output logic [W-1:0] S3,
    output logic [3:0]   S_valid,
    input  logic [3:0]   S_ready,
    output logic [7:0]   n_acc
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_e;

    ch_state_e      state_q [4];
    ch_state_e      state_d [4];
    logic [W-1:0]   data_q  [4];
    logic [W-1:0]   data_d  [4];
    logic [7:0]     n_acc_q;
    logic [7:0]     n_acc_d;
    logic [1:0]     sel_s;
    logic           in_xfer_s;
    logic [3:0]     out_xfer_s;

    // Handshake decode: only the selected channel can stall the producer.
    always_comb begin
        sel_s = {b1, b0};
        for (int k = 0; k < 4; k++) begin
            S_valid[k] = (state_q[k] == FULL);
        end
        out_xfer_s = S_valid & S_ready;
        e_ready    = rst_n & ((state_q[sel_s] == EMPTY) | S_ready[sel_s]);
        in_xfer_s  = e_valid & e_ready;
        if (in_xfer_s) begin
            n_acc_d = n_acc_q + 8'd1;
        end else begin
            n_acc_d = n_acc_q;
        end
    end

    // Per-channel next state; a refill in the drain cycle keeps the channel FULL.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            if (in_xfer_s && (sel_s == 2'(k))) begin
                state_d[k] = FULL;
                data_d[k]  = e;
            end else begin
                case (state_q[k])
                    FULL: begin
                        if (out_xfer_s[k]) begin
                            state_d[k] = EMPTY;
                        end else begin
                            state_d[k] = FULL;
                        end
                    end
                    EMPTY:   state_d[k] = EMPTY;
                    default: state_d[k] = EMPTY;
                endcase
            end
        end
    end

    // State, data and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
            end
            n_acc_q <= 8'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
            n_acc_q <= n_acc_d;
        end
    end

    assign S0    = data_q[0];
    assign S1    = data_q[1];
    assign S2    = data_q[2];
    assign S3    = data_q[3];
    assign n_acc = n_acc_q;

endmodule

// File: doc/demux1x4_reg.md
DEMUX1X4_REG -- requirements
Module: demux1x4_reg

Interface
REQ-001 The block SHALL have parameter W, default 8: data width of the input and of each output channel.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port e, input, W bits: data word to route.
REQ-005 The block SHALL have port e_valid, input, 1 bit: e, b1 and b0 are valid this cycle.
REQ-006 The block SHALL have port e_ready, output, 1 bit: the block accepts e this cycle.
REQ-007 The block SHALL have ports b1 and b0, inputs, 1 bit each: channel select, {b1,b0} = channel index 0..3.
REQ-008 The block SHALL have ports S0, S1, S2, S3, outputs, W bits each: per-channel output data.
REQ-009 The block SHALL have port S_valid, output, 4 bits: bit k set means Sk holds an undelivered word.
REQ-010 The block SHALL have port S_ready, input, 4 bits: bit k set means the consumer of channel k takes Sk this cycle.
REQ-011 The block SHALL have port n_acc, output, 8 bits: running count of accepted input words.

Function
REQ-012 An input transfer SHALL occur on a rising edge where e_valid=1 and e_ready=1; an output transfer on channel k SHALL occur where S_valid[k]=1 and S_ready[k]=1.
REQ-013 Channel routing SHALL be: {b1,b0}=00 to S0, 01 to S1, 10 to S2, 11 to S3, sampled only in the input transfer cycle.
REQ-014 Each channel SHALL be a one-entry buffer with a two-state FSM: EMPTY (S_valid[k]=0) and FULL (S_valid[k]=1).
REQ-015 Channel k transitions: EMPTY to FULL on an input transfer to k; FULL to EMPTY on an output transfer on k with no simultaneous input transfer to k; FULL stays FULL when both occur in the same cycle, and Sk takes the new word.
REQ-016 e_ready SHALL be combinational: 1 when rst_n=1 and the selected channel is EMPTY, or the selected channel is FULL and its S_ready bit is 1; otherwise 0.
REQ-017 e_ready SHALL depend only on the selected channel; a FULL unselected channel SHALL NOT stall the input.
REQ-018 Latency SHALL be one cycle: a word accepted on edge N SHALL appear on Sk with S_valid[k]=1 after edge N.
REQ-019 Sk SHALL hold its value unchanged while S_valid[k]=1 and S_ready[k]=0, and SHALL also hold its last value when EMPTY.
REQ-020 Unselected channels SHALL be unaffected by an input transfer: no data change and no state change.
REQ-021 Output transfers on different channels SHALL proceed independently and may occur in the same cycle as each other and as an input transfer.
REQ-022 n_acc SHALL increment by 1 on every input transfer and wrap from 255 to 0; output transfers SHALL NOT affect it.
REQ-023 e_valid=1 with e_ready=0 SHALL cause no state change; the producer keeps e, b1 and b0 stable until accepted.
REQ-024 No word SHALL be dropped or duplicated: every accepted word is presented on exactly one channel until that channel's output transfer.

Reset
REQ-025 On a rising edge with rst_n=0, all channels SHALL go EMPTY, S_valid=0000, S0..S3 SHALL be 0, and n_acc SHALL be 0.
REQ-026 While rst_n=0, e_ready SHALL be 0, and no transfer is counted or stored.
REQ-027 Reset asserted while channels are FULL SHALL discard their contents with no output transfer.
REQ-028 The first transfer after reset SHALL be possible on the first edge where rst_n=1.

Verification
REQ-029 The bench SHALL cover: reset, then e=0x5A, {b1,b0}=10, e_valid=1, S_ready=0000 -> after 1 edge S2=0x5A, S_valid=0100, n_acc=1; S0, S1 and S3 remain 0.
REQ-030 The bench SHALL cover: channel 2 FULL, S_ready[2]=0, new word 0x11 to channel 2 -> e_ready=0, S2 stays 0x5A, n_acc unchanged; then assert S_ready[2]=1 -> e_ready=1, and after the edge S2=0x11 with S_valid[2] still 1.
REQ-031 The bench SHALL cover: channel 2 FULL and stalled, input 0x33 to channel 0 -> accepted in 1 cycle, S0=0x33, S_valid=0101.
REQ-032 The bench SHALL cover: all four channels FULL, S_ready=1111, e_valid=0 -> after 1 edge S_valid=0000.
REQ-033 The bench SHALL cover: 256 accepted words with random select and random S_ready -> n_acc wraps to 0, and a scoreboard shows every word delivered in order per channel.
REQ-034 The bench SHALL cover: rst_n=0 for one edge while S_valid=1111 -> S_valid=0000, S0..S3=0, n_acc=0, and e_ready=0 during that cycle.
